// File: rtl/regfile_bus_master.sv
// Burst initiator for the register file bus: takes write/read burst commands,
// issues one register-file beat per cycle and returns read data as a stream.
module regfile_bus_master #(
    parameter int P_RegWidth    = 8,
    parameter int P_BitWidth    = 8,
    parameter int P_ReadLatency = 1,
    localparam int AW = (P_RegWidth > 1) ? $clog2(P_RegWidth) : 1
) (
    input  logic                  In_Clock_50MHz,
    input  logic                  In_Reset,
    input  logic                  In_CmdValid,
    output logic                  Out_CmdReady,
    input  logic                  In_CmdWrite,
    input  logic [AW-1:0]         In_CmdAddress,
    input  logic [AW-1:0]         In_CmdLength,
    input  logic                  In_WrDataValid,
    output logic                  Out_WrDataReady,
    input  logic [P_BitWidth-1:0] In_WrData,
    output logic                  Out_RdDataValid,
    output logic [P_BitWidth-1:0] Out_RdData,
    output logic                  Out_RdLast,
    output logic [AW-1:0]         Out_Address,
    output logic [P_BitWidth-1:0] Out_WriteData,
    output logic                  Out_Write,
    output logic                  Out_Read,
    input  logic [P_BitWidth-1:0] In_ReadData,
    output logic                  Out_Busy
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(P_RegWidth - 1);

    // Register index increment that wraps at the file size, not at 2**AW.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         count_q, count_d;
    logic                  rd_last_q;
    logic                  write_d, read_d, rd_last_d;
    logic [AW-1:0]         bus_addr_d;
    logic [P_BitWidth-1:0] wdata_d;
    logic                  cmd_fire, beat_fire;
    logic                  tap_vld, tap_last, rd_pipe_busy;

    assign Out_CmdReady    = (state_q == IDLE);
    assign Out_WrDataReady = (state_q == WRITE);
    assign cmd_fire        = In_CmdValid & Out_CmdReady;
    assign beat_fire       = In_WrDataValid & Out_WrDataReady;
    assign Out_Busy        = (state_q != IDLE) | Out_Write | Out_Read | rd_pipe_busy;

    // State register.
    always_ff @(posedge In_Clock_50MHz) begin
        if (In_Reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (cmd_fire) state_d = In_CmdWrite ? WRITE : READ_ISSUE;
            WRITE:      if (beat_fire && count_q == '0) state_d = IDLE;
            READ_ISSUE: if (count_q == '0) state_d = (Out_Read | rd_pipe_busy) ? READ_DRAIN : IDLE;
            READ_DRAIN: if (Out_RdDataValid & Out_RdLast) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Beat decisions: what goes on the bus next cycle and how the burst cursor moves.
    always_comb begin
        write_d    = 1'b0;
        read_d     = 1'b0;
        rd_last_d  = 1'b0;
        bus_addr_d = Out_Address;
        wdata_d    = Out_WriteData;
        addr_d     = addr_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    count_d = In_CmdLength;
                    if (In_CmdWrite) begin
                        addr_d = In_CmdAddress;
                    end else begin
                        // First read goes out on the cycle right after acceptance.
                        read_d     = 1'b1;
                        rd_last_d  = (In_CmdLength == '0);
                        bus_addr_d = In_CmdAddress;
                        addr_d     = addr_inc(In_CmdAddress);
                    end
                end
            end
            WRITE: begin
                if (beat_fire) begin
                    write_d    = 1'b1;
                    bus_addr_d = addr_q;
                    wdata_d    = In_WrData;
                    addr_d     = addr_inc(addr_q);
                    count_d    = count_q - 1'b1;
                end
            end
            READ_ISSUE: begin
                // count_q holds reads still to issue after the one now on the bus.
                if (count_q != '0) begin
                    read_d     = 1'b1;
                    rd_last_d  = (count_q == AW'(1));
                    bus_addr_d = addr_q;
                    addr_d     = addr_inc(addr_q);
                    count_d    = count_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus strobes and registered bus address/data.
    always_ff @(posedge In_Clock_50MHz) begin
        if (In_Reset) begin
            Out_Write     <= 1'b0;
            Out_Read      <= 1'b0;
            rd_last_q     <= 1'b0;
            Out_Address   <= '0;
            Out_WriteData <= '0;
        end else begin
            Out_Write     <= write_d;
            Out_Read      <= read_d;
            rd_last_q     <= rd_last_d;
            Out_Address   <= bus_addr_d;
            Out_WriteData <= wdata_d;
        end
    end

    // Burst cursor; always loaded on command acceptance before use.
    always_ff @(posedge In_Clock_50MHz) begin
        addr_q  <= addr_d;
        count_q <= count_d;
    end

    if (P_ReadLatency == 0) begin : g_lat0
        assign tap_vld      = Out_Read;
        assign tap_last     = rd_last_q;
        assign rd_pipe_busy = 1'b0;
    end else begin : g_pipe
        logic [P_ReadLatency-1:0] vld_p, last_p;

        // Outstanding-read valid tags; cleared by reset so late returns are dropped.
        always_ff @(posedge In_Clock_50MHz) begin
            if (In_Reset) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= Out_Read;
                for (int i = 1; i < P_ReadLatency; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        // Last-beat marker travelling alongside the valid tags.
        always_ff @(posedge In_Clock_50MHz) begin
            last_p[0] <= rd_last_q;
            for (int i = 1; i < P_ReadLatency; i++) last_p[i] <= last_p[i-1];
        end

        assign tap_vld      = vld_p[P_ReadLatency-1];
        assign tap_last     = last_p[P_ReadLatency-1];
        assign rd_pipe_busy = |vld_p;
    end

    // Read return stream: capture register-file data when its tag arrives.
    always_ff @(posedge In_Clock_50MHz) begin
        if (In_Reset) begin
            Out_RdDataValid <= 1'b0;
            Out_RdLast      <= 1'b0;
            Out_RdData      <= '0;
        end else begin
            Out_RdDataValid <= tap_vld;
            Out_RdLast      <= tap_vld & tap_last;
            if (tap_vld) Out_RdData <= In_ReadData;
        end
    end

endmodule
